dcache_flush_engine: RTL
========================

Name: dcache_flush_engine

Overview:
- Hardware replacement for end-of-run cache flushing: walks every set and way of the N-way data-cache SRAM and writes each valid dirty line back to Data_Memory over the existing enable/write/ack memory handshake.
- Sits beside dcache and shares its SRAM access and memory ports through an external arbiter, which grants the ports while busy_o is high.
- Supports clean-only and clean+invalidate modes, and reports the number of lines written back.

Parameters:
- NUM_SETS, 16, sets per way (power of 2, at least 2)
- NUM_WAYS, 2, associativity (at least 1)
- LINE_WIDTH, 256, bits per cache line
- ADDR_WIDTH, 32, byte-address width
- Derived localparams:
  - OFS_W = log2(LINE_WIDTH/8)
  - IDX_W = log2(NUM_SETS)
  - WAY_W = max(1, log2(NUM_WAYS))
  - TAG_W = ADDR_WIDTH - IDX_W - OFS_W (23 at defaults)
  - CNT_W = log2(NUM_SETS*NUM_WAYS) + 1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle flush request, accepted only in IDLE
- invalidate_i  in  1  sampled with start_i; 1 = clear valid as well as dirty
- busy_o  out  1  high from the cycle after acceptance until DONE
- done_o  out  1  one-cycle pulse at flush completion
- wb_count_o  out  CNT_W  lines written back by the last flush; held until the next start
- sram_idx_o  out  IDX_W  set being read or updated
- sram_way_o  out  WAY_W  way being read or updated
- sram_rd_o  out  1  read strobe; data is valid on the next cycle
- sram_valid_i  in  1  valid bit of the addressed entry
- sram_dirty_i  in  1  dirty bit of the addressed entry
- sram_tag_i  in  TAG_W  tag of the addressed entry
- sram_data_i  in  LINE_WIDTH  line data of the addressed entry
- sram_upd_o  out  1  one-cycle status-update strobe
- sram_clr_dirty_o  out  1  with sram_upd_o: clear dirty
- sram_clr_valid_o  out  1  with sram_upd_o: clear valid
- mem_enable_o  out  1  memory request
- mem_write_o  out  1  always 1 while mem_enable_o is high
- mem_addr_o  out  ADDR_WIDTH  {tag, idx, OFS_W'b0}
- mem_data_o  out  LINE_WIDTH  line being written back
- mem_ack_i  in  1  memory completion, one-cycle pulse

Behaviour:
- Reset (rst_i low, asynchronous):
  - state is IDLE; set and way counters are 0.
  - All outputs are 0, including wb_count_o.
- FSM states: IDLE, RD, CHK, WB, UPD, NXT, DONE.
- IDLE:
  - start_i=1 latches invalidate_i, clears the set/way counters and wb_count_o, and goes to RD.
  - start_i while busy is ignored.
- RD: sram_rd_o=1 for one cycle; go to CHK.
- CHK (SRAM outputs valid):
  - valid & dirty: register tag and data into the memory output registers, go to WB.
  - valid & !dirty & invalidate: go to UPD.
  - Otherwise: go to NXT.
- WB:
  - mem_enable_o=1 and mem_write_o=1, with address and data held stable, until mem_ack_i is seen.
  - On the ack cycle: deassert enable on the next edge, increment wb_count_o, go to UPD.
  - No timeout.
- UPD:
  - sram_upd_o=1 for one cycle.
  - sram_clr_dirty_o=1 when the line was written back.
  - sram_clr_valid_o = latched invalidate.
  - Go to NXT.
- NXT:
  - Order is way-minor: way increments first; on wrap to 0, set increments.
  - After the last set and last way, go to DONE; otherwise go to RD.
- DONE: done_o=1 for one cycle, busy_o drops in the same cycle, go to IDLE.
- Latency:
  - Clean entry: 3 cycles (RD, CHK, NXT).
  - Dirty entry: 5 cycles plus memory latency.
  - Empty cache at defaults: 32*3 + 1 = 97 cycles from acceptance to done_o.
- mem_ack_i outside WB is ignored.
- rst_i asserted mid-flush:
  - Immediate return to IDLE with all outputs 0.
  - A partially issued memory write is abandoned; the memory side is reset by the same rst_i.
- mem_addr_o offset bits are always 0. The tag is placed at [ADDR_WIDTH-1 -: TAG_W].

Decomposition:
- Shared package cache_pkg:
  - FSM state enum.
  - Helper function computing TAG_W/IDX_W/OFS_W from the parameters.
  - Line-address assembly function {tag, idx, ofs0}.
- Sub-module flush_walker: the set/way counter with wrap and last flags, separated so the engine FSM only sees step/last signals.

Test Plan:
- Empty cache, start_i with invalidate_i=0:
  - No mem_enable_o.
  - done_o exactly 97 cycles after acceptance.
  - wb_count_o=0.
- Set 3 way 1, valid/dirty, tag 23'h000001, data 256'hECFA…; memory acks 2 cycles after enable:
  - One write at mem_addr_o=32'h0000_0260 with that data.
  - UPD with clr_dirty=1, clr_valid=0.
  - wb_count_o=1.
- All 32 entries valid/dirty, invalidate_i=1:
  - 32 writes in order idx0w0, idx0w1, idx1w0, …
  - Every UPD has clr_dirty=1 and clr_valid=1.
  - wb_count_o=32.
- Valid clean entry with invalidate_i=1:
  - No memory write.
  - UPD with clr_dirty=0, clr_valid=1.
- Second start_i pulse while busy; stray mem_ack_i in IDLE/RD:
  - Both are ignored.
  - Walk and count are unchanged.
- rst_i low during WB (enable held, no ack):
  - Outputs go to 0 asynchronously.
  - After release, a new start_i flushes from set 0, way 0.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and helpers for the data-cache flush engine: FSM encoding,
// address-field width helpers and line-address assembly.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CHK,
    ST_WB,
    ST_UPD,
    ST_NXT,
    ST_DONE
  } flush_state_e;

  // Widest byte address the line_addr helper can assemble.
  localparam int MAX_ADDR_W = 64;

  function automatic int ofs_width(input int line_width);
    return $clog2(line_width / 8);
  endfunction

  function automatic int idx_width(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_width(input int addr_w, input int num_sets, input int line_width);
    return addr_w - idx_width(num_sets) - ofs_width(line_width);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] line_addr(
    input logic [MAX_ADDR_W-1:0] tag,
    input logic [MAX_ADDR_W-1:0] idx,
    input int                    idx_w,
    input int                    ofs_w
  );
    return (tag << (idx_w + ofs_w)) | (idx << ofs_w);
  endfunction

endpackage

// File: rtl/flush_walker.sv
// Set/way walk counter for the flush engine: way-minor order, with a flag
// marking the final entry so the FSM only deals in step/last.
module flush_walker #(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  parameter int IDX_W    = 4,
  parameter int WAY_W    = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             step_i,
  output logic [IDX_W-1:0] idx_o,
  output logic [WAY_W-1:0] way_o,
  output logic             last_o
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WAY_W-1:0] way_q, way_d;
  logic             last_way;

  assign last_way = (way_q == WAY_W'(NUM_WAYS - 1));
  assign last_o   = last_way && (idx_q == IDX_W'(NUM_SETS - 1));
  assign idx_o    = idx_q;
  assign way_o    = way_q;

  always_comb begin
    idx_d = idx_q;
    way_d = way_q;
    if (clr_i) begin
      idx_d = '0;
      way_d = '0;
    end else if (step_i) begin
      if (last_way) begin
        way_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        way_d = way_q + WAY_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_q <= '0;
      way_q <= '0;
    end else begin
      idx_q <= idx_d;
      way_q <= way_d;
    end
  end

endmodule

// File: rtl/dcache_flush_engine.sv
// Walks every set/way of the data-cache SRAM, writes valid dirty lines back to
// memory and clears dirty (and optionally valid) status behind them.
module dcache_flush_engine
  import cache_pkg::*;
#(
  parameter int  NUM_SETS   = 16,
  parameter int  NUM_WAYS   = 2,
  parameter int  LINE_WIDTH = 256,
  parameter int  ADDR_WIDTH = 32,
  localparam int OFS_W      = ofs_width(LINE_WIDTH),
  localparam int IDX_W      = idx_width(NUM_SETS),
  localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int TAG_W      = tag_width(ADDR_WIDTH, NUM_SETS, LINE_WIDTH),
  localparam int CNT_W      = $clog2(NUM_SETS * NUM_WAYS) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  invalidate_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      wb_count_o,
  output logic [IDX_W-1:0]      sram_idx_o,
  output logic [WAY_W-1:0]      sram_way_o,
  output logic                  sram_rd_o,
  input  logic                  sram_valid_i,
  input  logic                  sram_dirty_i,
  input  logic [TAG_W-1:0]      sram_tag_i,
  input  logic [LINE_WIDTH-1:0] sram_data_i,
  output logic                  sram_upd_o,
  output logic                  sram_clr_dirty_o,
  output logic                  sram_clr_valid_o,
  output logic                  mem_enable_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  input  logic                  mem_ack_i
);

  flush_state_e          state_q, state_d;
  logic                  inv_q, inv_d;
  logic                  wbf_q, wbf_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LINE_WIDTH-1:0] data_q, data_d;
  logic                  walk_clr, walk_step, walk_last;

  flush_walker #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS),
    .IDX_W    (IDX_W),
    .WAY_W    (WAY_W)
  ) u_walker (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr_i  (walk_clr),
    .step_i (walk_step),
    .idx_o  (sram_idx_o),
    .way_o  (sram_way_o),
    .last_o (walk_last)
  );

  always_comb begin
    state_d   = state_q;
    inv_d     = inv_q;
    wbf_d     = wbf_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    data_d    = data_q;
    walk_clr  = 1'b0;
    walk_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          inv_d    = invalidate_i;
          cnt_d    = '0;
          wbf_d    = 1'b0;
          walk_clr = 1'b1;
          state_d  = ST_RD;
        end
      end
      ST_RD: begin
        wbf_d   = 1'b0;
        state_d = ST_CHK;
      end
      ST_CHK: begin
        if (sram_valid_i && sram_dirty_i) begin
          addr_d  = ADDR_WIDTH'(line_addr(MAX_ADDR_W'(sram_tag_i), MAX_ADDR_W'(sram_idx_o),
                                          IDX_W, OFS_W));
          data_d  = sram_data_i;
          state_d = ST_WB;
        end else if (sram_valid_i && inv_q) begin
          state_d = ST_UPD;
        end else begin
          state_d = ST_NXT;
        end
      end
      ST_WB: begin
        // Acks are only meaningful here; any stray pulse elsewhere falls through.
        if (mem_ack_i) begin
          cnt_d   = cnt_q + CNT_W'(1);
          wbf_d   = 1'b1;
          state_d = ST_UPD;
        end
      end
      ST_UPD:  state_d = ST_NXT;
      ST_NXT: begin
        walk_step = 1'b1;
        state_d   = walk_last ? ST_DONE : ST_RD;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      inv_q   <= 1'b0;
      wbf_q   <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      inv_q   <= inv_d;
      wbf_q   <= wbf_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign busy_o           = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done_o           = (state_q == ST_DONE);
  assign wb_count_o       = cnt_q;
  assign sram_rd_o        = (state_q == ST_RD);
  assign sram_upd_o       = (state_q == ST_UPD);
  assign sram_clr_dirty_o = (state_q == ST_UPD) && wbf_q;
  assign sram_clr_valid_o = (state_q == ST_UPD) && inv_q;
  assign mem_enable_o     = (state_q == ST_WB);
  assign mem_write_o      = (state_q == ST_WB);
  assign mem_addr_o       = addr_q;
  assign mem_data_o       = data_q;

endmodule
